// File: rtl/dcfir_coe_sequencer.sv
// Coefficient table sequencer for the DC FIR: stores per-tap {sel, coefficients}
// and replays entries 0..N-1 on consecutive cycles, then waits for the filter to drain.
module dcfir_coe_sequencer #(
    parameter int DEPTH     = 32,
    parameter int DRAIN_CYC = 8
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [65:0] wr_data,
    input  logic        start,
    input  logic [5:0]  num_taps,
    input  logic        abort,
    output logic [5:0]  sel,
    output logic [9:0]  coe_real1,
    output logic [9:0]  coe_real2,
    output logic [9:0]  coe_real3,
    output logic [9:0]  coe_imag1,
    output logic [9:0]  coe_imag2,
    output logic [9:0]  coe_imag3,
    output logic        coe_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [6:0]       DEPTH_L    = 7'(DEPTH);
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [65:0]        table_q [DEPTH];
    logic [5:0]         idx_q, idx_d;
    logic [5:0]         n_q, n_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [65:0]        out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wr_ok;
    logic               len_ok;
    logic [65:0]        rd_entry;

    // The table is frozen while a sequence is being issued or drained.
    assign wr_ok    = wr_en && (state_q == IDLE || state_q == DONE);
    assign len_ok   = (num_taps != 6'd0) && ({1'b0, num_taps} <= DEPTH_L);
    assign rd_entry = table_q[idx_q[IDX_W-1:0]];

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && wr_addr == 5'(i)) begin
                    table_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            drn_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            drn_q   <= drn_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        drn_d   = drn_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        n_d     = num_taps;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                out_d   = rd_entry;
                valid_d = 1'b1;
                // Hold idx on the last entry so it never leaves 0..N-1.
                if (idx_q == n_q - 6'd1) begin
                    state_d = DRAIN;
                    drn_d   = DRAIN_INIT;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            DRAIN: begin
                if (drn_q <= DRN_W'(1)) begin
                    state_d = DONE;
                    drn_d   = '0;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
            idx_d   = '0;
            drn_d   = '0;
            out_d   = '0;
            valid_d = 1'b0;
        end
    end

    assign busy_d = (state_d == RUN) || (state_d == DRAIN);
    assign done_d = (state_d == DONE);

    assign sel       = out_q[65:60];
    assign coe_real1 = out_q[59:50];
    assign coe_real2 = out_q[49:40];
    assign coe_real3 = out_q[39:30];
    assign coe_imag1 = out_q[29:20];
    assign coe_imag2 = out_q[19:10];
    assign coe_imag3 = out_q[9:0];
    assign coe_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dcfir_coe_sequencer.sv
// Directed bench for dcfir_coe_sequencer: a per-cycle vector table for the basic
// flows plus hand-written sequences for full depth, abort, table protection and reset.
module tb_dcfir_coe_sequencer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [65:0] wr_data;
    logic        start;
    logic [5:0]  num_taps;
    logic        abort;
    logic [5:0]  sel;
    logic [9:0]  coe_real1, coe_real2, coe_real3;
    logic [9:0]  coe_imag1, coe_imag2, coe_imag3;
    logic        coe_valid, busy, done, err;
    logic [65:0] out_vec;

    int checks   = 0;
    int failures = 0;

    dcfir_coe_sequencer #(.DEPTH(32), .DRAIN_CYC(8)) dut (
        .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_taps(num_taps), .abort(abort), .sel(sel),
        .coe_real1(coe_real1), .coe_real2(coe_real2), .coe_real3(coe_real3),
        .coe_imag1(coe_imag1), .coe_imag2(coe_imag2), .coe_imag3(coe_imag3),
        .coe_valid(coe_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    assign out_vec = {sel, coe_real1, coe_real2, coe_real3, coe_imag1, coe_imag2, coe_imag3};

    localparam logic [65:0] E0 = {6'd3, 10'h001, 50'd0};
    localparam logic [65:0] E1 = {6'd7, 50'd0, 10'h3FF};
    localparam logic [65:0] E2 = {6'd12, 10'h155, 10'h0AA, 10'h000, 10'h001, 10'h002, 10'h003};

    typedef struct {
        string       name;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [65:0] wr_data;
        logic        start;
        logic [5:0]  num_taps;
        logic        abort;
        logic [65:0] exp_out;
        logic        exp_valid;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [65:0] ent(int k);
        return {6'(k), 10'(k * 7 + 1), 40'd0, 10'(1023 - k)};
    endfunction

    function automatic void add(string nm, logic we, logic [4:0] wa, logic [65:0] wd,
                                logic st, logic [5:0] nt, logic ab, logic [65:0] eo,
                                logic ev, logic eb, logic ed, logic ee);
        vec_t v;
        v.name = nm; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.start = st; v.num_taps = nt; v.abort = ab;
        v.exp_out = eo; v.exp_valid = ev; v.exp_busy = eb; v.exp_done = ed; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    function automatic void add_drain(string nm, logic [65:0] eo, int n);
        for (int i = 0; i < n; i++) begin
            add(nm, 0, 0, 0, 0, 0, 0, eo, 0, 1, 0, 0);
        end
    endfunction

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; num_taps = 0; abort = 0;
    endtask

    task automatic check_status(input string nm, input logic [65:0] eo,
                                input logic ev, input logic eb, input logic ed, input logic ee);
        check({nm, ".out"}, out_vec, eo);
        check({nm, ".valid"}, 66'(coe_valid), 66'(ev));
        check({nm, ".busy"}, 66'(busy), 66'(eb));
        check({nm, ".done"}, 66'(done), 66'(ed));
        check({nm, ".err"}, 66'(err), 66'(ee));
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        check(nm, 66'(seen), 66'(1));
        step();
    endtask

    task automatic start_run(input logic [5:0] n);
        start = 1; num_taps = n;
        step();
        start = 0; num_taps = 0;
    endtask

    initial begin
        int seen_done;
        vec_t v;

        idle_inputs();
        rst = 1;
        #2;
        check_status("reset", 66'd0, 0, 0, 0, 0);
        #10;
        rst = 0;

        // Basic two-entry run, then illegal lengths.
        add("wr0",  1, 0, E0, 0, 0, 0, 66'd0, 0, 0, 0, 0);
        add("wr1",  1, 1, E1, 0, 0, 0, 66'd0, 0, 0, 0, 0);
        add("st2",  0, 0, 0,  1, 2, 0, 66'd0, 0, 1, 0, 0);
        add("iss0", 0, 0, 0,  0, 0, 0, E0,    1, 1, 0, 0);
        add("iss1", 0, 0, 0,  0, 0, 0, E1,    1, 1, 0, 0);
        add_drain("drain_a", E1, 7);
        add("done_a", 0, 0, 0, 0, 0, 0, E1, 0, 0, 1, 0);
        add("idle_a", 0, 0, 0, 0, 0, 0, E1, 0, 0, 0, 0);
        add("len0",   0, 0, 0, 1, 0,  0, E1, 0, 0, 0, 1);
        add("len0_z", 0, 0, 0, 0, 0,  0, E1, 0, 0, 0, 0);
        add("len33",  0, 0, 0, 1, 33, 0, E1, 0, 0, 0, 1);
        add("len33_z",0, 0, 0, 0, 0,  0, E1, 0, 0, 0, 0);
        add("len63",  0, 0, 0, 1, 63, 0, E1, 0, 0, 0, 1);
        add("len63_z",0, 0, 0, 0, 0,  0, E1, 0, 0, 0, 0);
        // Abort in IDLE is ignored; single-entry run; DONE accepts writes but not start.
        add("st1_ab", 0, 0, 0, 1, 1, 1, E1, 0, 1, 0, 0);
        add("iss_b",  0, 0, 0, 0, 0, 0, E0, 1, 1, 0, 0);
        add_drain("drain_b", E0, 7);
        add("done_b", 0, 0, 0,  0, 0, 0, E0, 0, 0, 1, 0);
        add("in_done",1, 0, E2, 1, 2, 0, E0, 0, 0, 0, 0);
        add("st1_c",  0, 0, 0,  1, 1, 0, E0, 0, 1, 0, 0);
        add("iss_c",  0, 0, 0,  0, 0, 0, E2, 1, 1, 0, 0);
        add_drain("drain_c", E2, 7);
        add("done_c", 0, 0, 0, 0, 0, 0, E2, 0, 0, 1, 0);
        add("idle_c", 0, 0, 0, 0, 0, 0, E2, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
            start = v.start; num_taps = v.num_taps; abort = v.abort;
            step();
            check_status(v.name, v.exp_out, v.exp_valid, v.exp_busy, v.exp_done, v.exp_err);
        end
        idle_inputs();

        // Full depth with writes attempted during RUN and DRAIN.
        for (int k = 0; k < 32; k++) begin
            wr_en = 1; wr_addr = 5'(k); wr_data = ent(k);
            step();
        end
        idle_inputs();
        start_run(6'd32);
        check("full.busy", 66'(busy), 66'(1));
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                wr_en = 1; wr_addr = 0; wr_data = {6'd9, 60'd0};
            end
            step();
            wr_en = 0;
            check($sformatf("full.out%0d", k), out_vec, ent(k));
            check($sformatf("full.valid%0d", k), 66'(coe_valid), 66'(1));
        end
        wr_en = 1; wr_addr = 1; wr_data = {6'd9, 60'd0};
        step();
        wr_en = 0;
        check("full.hold", out_vec, ent(31));
        check("full.novalid", 66'(coe_valid), 66'(0));
        wait_done("full.done");
        start_run(6'd2);
        step();
        check("prot.entry0", out_vec, ent(0));
        step();
        check("prot.entry1", out_vec, ent(1));
        wait_done("prot.done");

        // Abort at the 5th valid cycle.
        start_run(6'd16);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("abort.out%0d", k), out_vec, ent(k));
        end
        abort = 1;
        step();
        abort = 0;
        check_status("abort.run", 66'd0, 0, 0, 0, 0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen_done++;
        end
        check("abort.quiet", 66'(seen_done), 66'(0));

        // Abort during DRAIN.
        start_run(6'd1);
        step();
        step();
        check("abort_d.busy", 66'(busy), 66'(1));
        abort = 1;
        step();
        abort = 0;
        check_status("abort.drain", 66'd0, 0, 0, 0, 0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen_done++;
        end
        check("abort_d.nodone", 66'(seen_done), 66'(0));

        // Start while busy is ignored without error.
        start_run(6'd4);
        step();
        start = 1; num_taps = 0;
        step();
        start = 0;
        check_status("busy_start", ent(1), 1, 1, 0, 0);
        wait_done("busy_start.done");

        // Same-edge write and start: first read sees the new entry.
        wr_en = 1; wr_addr = 0; wr_data = ent(40);
        start_run(6'd1);
        wr_en = 0;
        step();
        check("wr_start.out", out_vec, ent(40));
        wait_done("wr_start.done");

        // Asynchronous reset mid-DRAIN, between edges.
        start_run(6'd2);
        step();
        step();
        step();
        #3;
        rst = 1;
        #1;
        check_status("async_rst", 66'd0, 0, 0, 0, 0);
        step();
        rst = 0;
        start = 1; num_taps = 2;
        step();
        start = 0; num_taps = 0;
        check("post_rst.busy", 66'(busy), 66'(1));
        step();
        check_status("post_rst.e0", 66'd0, 1, 1, 0, 0);
        step();
        check_status("post_rst.e1", 66'd0, 1, 1, 0, 0);
        wait_done("post_rst.done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcfir_coe_sequencer.md
DCFIR_COE_SEQUENCER -- requirements
Module: dcfir_coe_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of table entries (tap positions).
REQ-002 SHALL have parameter DRAIN_CYC, default 8: cycles allowed for the filter pipeline to flush after the last entry is issued.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on posedge CLK.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: table write strobe.
REQ-006 SHALL have port wr_addr, input, 5 bits: table write index.
REQ-007 SHALL have port wr_data, input, 66 bits: {sel[5:0], coe_real1, coe_real2, coe_real3, coe_imag1, coe_imag2, coe_imag3}, each coefficient 10 bits.
REQ-008 SHALL have port start, input, 1 bit: one-cycle request to begin a sequence.
REQ-009 SHALL have port num_taps, input, 6 bits: number of entries to issue, legal range 1..DEPTH.
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel of an active sequence.
REQ-011 SHALL have port sel, output, 6 bits: delay-line tap select for the filter mux.
REQ-012 SHALL have ports coe_real1/2/3 and coe_imag1/2/3, outputs, 10 bits each: coefficients driven to the filter.
REQ-013 SHALL have port coe_valid, output, 1 bit: high when sel and the coefficients carry a fresh entry.
REQ-014 SHALL have ports busy, done and err, outputs, 1 bit each: status.

Function
REQ-015 SHALL implement a register table of DEPTH x 66 bits.
- A write with wr_en=1 in IDLE or DONE SHALL commit on the same edge.
- A write in RUN or DRAIN SHALL be ignored.
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE: start=1 with num_taps in 1..DEPTH SHALL capture N=num_taps, clear idx to 0 and enter RUN on that edge.
REQ-018 IDLE: start=1 with num_taps=0 or num_taps>DEPTH SHALL pulse err for one cycle on the next edge and stay in IDLE.
REQ-019 RUN, each edge:
- sel/coe outputs <= table[idx], coe_valid <= 1, idx <= idx+1.
- When idx==N-1, SHALL enter DRAIN with drain counter = DRAIN_CYC.
REQ-020 First-entry latency: entry 0 SHALL appear on the outputs one cycle after the start edge; entry k appears k+1 cycles after it.
REQ-021 DRAIN:
- coe_valid=0; sel/coe outputs hold the last issued entry.
- Counter decrements each edge; at count 1, SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-023 busy SHALL be 1 in RUN and DRAIN, 0 otherwise; start while busy SHALL be ignored without error.
REQ-024 abort=1 in RUN or DRAIN, on that edge:
- SHALL force IDLE, clear coe_valid and zero sel/coe outputs.
- done SHALL NOT pulse.
- abort SHALL take priority over every other transition; abort in IDLE/DONE has no effect.
REQ-025 A same-edge write and start in IDLE SHALL both take effect; the first RUN read SHALL see the newly written entry.
REQ-026 idx SHALL never exceed N-1; for N=DEPTH, no wrap or out-of-range read SHALL occur.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL asynchronously force:
- state IDLE, idx 0, drain counter 0;
- sel=0, all coefficients 0;
- coe_valid=0, busy=0, done=0, err=0.
REQ-029 rst SHALL clear the table to all zeros.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first edge with rst low.
REQ-031 rst asserted mid-RUN SHALL abandon the sequence without a done pulse.

Verification
REQ-032 Basic run: write entry0={sel=3, coe_real1=10'h001, others 0} and entry1={sel=7, coe_imag3=10'h3FF}; start with num_taps=2.
- coe_valid high for exactly 2 cycles showing sel 3 then 7.
- busy high for 2+8 cycles, then done high for 1 cycle.
REQ-033 Full depth: num_taps=32 with entry k sel=k -> sel steps 0..31 on consecutive cycles, coe_valid 32 cycles, no wrap.
REQ-034 Illegal length: start with num_taps=0, then with num_taps=33 -> err pulses once for each, busy stays 0, outputs unchanged.
REQ-035 Abort mid-run: num_taps=16, abort at the 5th valid cycle -> next cycle coe_valid=0, sel=0, busy=0, done never asserts.
REQ-036 Protected table: write entry0 sel=9 during RUN, then start a new run -> entry0 still issues its original sel value.
REQ-037 Async reset: assert rst mid-DRAIN, between clock edges -> all outputs 0 immediately; the table reads all zeros on a subsequent run.
